// File: rtl/xor_serial_sched.sv
// xor_serial_sched: round-robin, LSB-first scheduler for one shared 1-bit XOR gate.
// Define XOR_SCHED_PARITY_EN to add res_parity, the XOR-reduction of res_data.
module xor_serial_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             xor_a,
  output logic             xor_b,
  input  logic             xor_q,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
`ifdef XOR_SCHED_PARITY_EN
  output logic             res_parity,
`endif
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q;
  logic rr_q, id_q;
  logic [CW-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q, data_q;
  logic idle, g0, g1;
  assign idle = state_q == IDLE;
  // rr_q high means req1 wins a tie
  assign g0 = idle & req0_valid & (~req1_valid | ~rr_q);
  assign g1 = idle & req1_valid & ~g0;
  assign req0_ready = g0;
  assign req1_ready = g1;
  assign xor_a = (state_q == SHIFT) & a_q[0];
  assign xor_b = (state_q == SHIFT) & b_q[0];
  assign res_valid = state_q == DONE;
  assign busy = ~idle;
  assign res_data = data_q;
  assign res_id = id_q;
`ifdef XOR_SCHED_PARITY_EN
  logic par_q;
  assign res_parity = par_q;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q <= 1'b0;
      id_q <= 1'b0;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      data_q <= '0;
`ifdef XOR_SCHED_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (g0 | g1) begin
          a_q <= g1 ? req1_a : req0_a;
          b_q <= g1 ? req1_b : req0_b;
          id_q <= g1;
          rr_q <= g0;
          cnt_q <= '0;
          state_q <= SHIFT;
`ifdef XOR_SCHED_PARITY_EN
          par_q <= 1'b0;
`endif
        end
        SHIFT: begin
          data_q[cnt_q] <= xor_q;
          a_q <= a_q >> 1;
          b_q <= b_q >> 1;
          cnt_q <= cnt_q + 1'b1;
`ifdef XOR_SCHED_PARITY_EN
          par_q <= par_q ^ xor_q;
`endif
          if (cnt_q == CW'(WIDTH - 1)) state_q <= DONE;
        end
        DONE: if (res_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_xor_serial_sched.sv
// tb_xor_serial_sched: table, corner-case and random checks of xor_serial_sched (8-bit and 4-bit).
module tb_xor_serial_sched;
  localparam int W = 8;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic req0_valid = 0, req1_valid = 0, res_ready = 0;
  logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic req0_ready, req1_ready, xor_a, xor_b, xor_q, res_valid, res_id, busy;
  logic [W-1:0] res_data;
  assign xor_q = xor_a ^ xor_b;
`ifdef XOR_SCHED_PARITY_EN
  logic res_parity, par4;
`endif
  xor_serial_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .xor_a(xor_a), .xor_b(xor_b), .xor_q(xor_q),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
`ifdef XOR_SCHED_PARITY_EN
    .res_parity(res_parity),
`endif
    .busy(busy));
  logic v4 = 0, rv4, r0r4, r1r4, xa4, xb4, id4, busy4;
  logic [3:0] a4 = 0, b4 = 0, z4 = 0, d4;
  xor_serial_sched #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v4), .req0_ready(r0r4), .req0_a(a4), .req0_b(b4),
    .req1_valid(1'b0), .req1_ready(r1r4), .req1_a(z4), .req1_b(z4),
    .xor_a(xa4), .xor_b(xb4), .xor_q(xa4 ^ xb4),
    .res_valid(rv4), .res_ready(1'b1), .res_data(d4), .res_id(id4),
`ifdef XOR_SCHED_PARITY_EN
    .res_parity(par4),
`endif
    .busy(busy4));
  typedef struct {
    bit v0, v1;
    logic [W-1:0] a0, b0, a1, b1;
    int stall;
    bit id;
    logic [W-1:0] d;
  } vec_t;
  vec_t tv[8];
  int vec = 0, err = 0;
  bit last = 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic op(input bit v0, input bit v1, input logic [W-1:0] a0, input logic [W-1:0] b0,
                    input logic [W-1:0] a1, input logic [W-1:0] b1, input int stall,
                    input bit eid, input logic [W-1:0] ed);
    logic [W-1:0] ea;
    int n;
    ea = eid ? a1 : a0;
    @(negedge clk);
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    res_ready = 0;
    #1 chk("grant", {req1_ready, req0_ready}, eid ? 2 : 1);
    @(negedge clk);
    req0_valid = 0; req1_valid = 0;
    last = eid;
    n = 0;
    while (!res_valid && n < 4 * W) begin
      if (n < W) chk("xor_a", xor_a, ea[n]);
      chk("busy", busy, 1);
      @(negedge clk);
      n++;
    end
    chk("latency", n, W);
    req0_valid = 1; req1_valid = 1;
    repeat (stall) begin
      #1;
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, ed);
      chk("hold_ready", {req1_ready, req0_ready}, 0);
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0;
    chk("res_valid", res_valid, 1);
    chk("res_data", res_data, ed);
    chk("res_id", res_id, eid);
`ifdef XOR_SCHED_PARITY_EN
    chk("res_parity", res_parity, ^ed);
`endif
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk("valid_fall", res_valid, 0);
    chk("idle", busy, 0);
  endtask
  initial begin
    int n, sel;
    logic [W-1:0] ra0, rb0, ra1, rb1;
    bit eid;
    tv[0] = '{1, 1, 8'hA5, 8'h3C, 8'h12, 8'h34, 0, 0, 8'h99};
    tv[1] = '{1, 1, 8'h0F, 8'hF0, 8'h12, 8'h34, 0, 1, 8'h26};
    tv[2] = '{1, 1, 8'hA5, 8'h3C, 8'h00, 8'h00, 5, 0, 8'h99};
    tv[3] = '{1, 1, 8'h00, 8'h00, 8'h80, 8'h01, 0, 1, 8'h81};
    tv[4] = '{0, 1, 8'h00, 8'h00, 8'h5A, 8'h5A, 1, 1, 8'h00};
    tv[5] = '{1, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 0, 0, 8'hFF};
    tv[6] = '{1, 0, 8'h01, 8'h00, 8'h00, 8'h00, 0, 0, 8'h01};
    tv[7] = '{0, 1, 8'h00, 8'h00, 8'hC3, 8'h3C, 2, 1, 8'hFF};
    repeat (2) @(negedge clk);
    chk("rst_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", res_data, 0);
    chk("rst_id", res_id, 0);
    chk("rst_xor", {xor_a, xor_b}, 0);
    rst_n = 1;
    foreach (tv[i])
      op(tv[i].v0, tv[i].v1, tv[i].a0, tv[i].b0, tv[i].a1, tv[i].b1, tv[i].stall, tv[i].id, tv[i].d);
    @(negedge clk);
    req1_valid = 1; req1_a = 8'h77; req1_b = 8'h11;
    @(negedge clk);
    req1_valid = 0;
    repeat (3) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst_n = 0;
    @(negedge clk);
    chk("abort_valid", res_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_data", res_data, 0);
    chk("abort_id", res_id, 0);
    chk("abort_xor", {xor_a, xor_b}, 0);
    rst_n = 1;
    last = 1;
    repeat (W + 2) begin
      @(negedge clk);
      chk("no_valid", res_valid, 0);
    end
    op(1, 1, 8'hFF, 8'h0F, 8'h12, 8'h34, 0, 0, 8'hF0);
    for (int k = 0; k < 24; k++) begin
      sel = $urandom_range(1, 3);
      ra0 = W'($urandom); rb0 = W'($urandom); ra1 = W'($urandom); rb1 = W'($urandom);
      eid = (sel == 3) ? ~last : (sel == 2);
      op(sel[0], sel[1], ra0, rb0, ra1, rb1, $urandom_range(0, 3), eid, eid ? ra1 ^ rb1 : ra0 ^ rb0);
    end
    @(negedge clk);
    v4 = 1; a4 = 4'h9; b4 = 4'h6;
    @(negedge clk);
    v4 = 0;
    n = 0;
    while (!rv4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("w4_latency", n, 4);
    chk("w4_data", d4, 4'hF);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
